// File: rtl/glyph_rain_pkg.sv
// Shared types, constants and palette table for the glyph rain engine.
// Column state layout, walk FSM encoding and LFSR helpers live here.
package glyph_rain_pkg;

    localparam int HEAD_W  = 7;
    localparam int STEP_W  = 2;
    localparam int SPEED_W = 2;
    localparam int TRAIL_W = 4;
    localparam int SEED_W  = 6;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [SPEED_W-1:0] RESET_SPEED = 2'd1;
    localparam logic [TRAIL_W-1:0] RESET_TRAIL = 4'd4;
    localparam logic [TRAIL_W-1:0] MIN_TRAIL   = 4'd4;

    typedef struct packed {
        logic [HEAD_W-1:0]  head;
        logic [STEP_W-1:0]  step;
        logic [SPEED_W-1:0] speed;
        logic [TRAIL_W-1:0] trail;
        logic [SEED_W-1:0]  seed;
    } col_state_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } walk_state_t;

    typedef logic [5:0] rgb_t;

    // Index 0 is the dimmest tail shade, index 7 sits right behind the head.
    localparam rgb_t PALETTE [4][8] = '{
        '{6'h04, 6'h04, 6'h08, 6'h08, 6'h0C, 6'h0C, 6'h1D, 6'h2E},  // green
        '{6'h10, 6'h10, 6'h20, 6'h24, 6'h30, 6'h34, 6'h38, 6'h3C},  // amber
        '{6'h01, 6'h01, 6'h02, 6'h05, 6'h06, 6'h0A, 6'h0F, 6'h1F},  // cyan
        '{6'h15, 6'h15, 6'h15, 6'h2A, 6'h2A, 6'h2A, 6'h2A, 6'h2A}   // mono
    };

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
        return (nxt == 16'h0000) ? LFSR_SEED : nxt;
    endfunction

endpackage

// File: rtl/glyph_rain_column_state.sv
// Per-column animation state: one combinational pixel read port and one
// read-modify-write port used by the column-update walk.
module glyph_rain_column_state
    import glyph_rain_pkg::*;
#(
    parameter int NUM_COLS = 80,
    parameter int NUM_ROWS = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         pix_col,
    output logic [HEAD_W-1:0]  pix_head,
    output logic [TRAIL_W-1:0] pix_trail,
    output logic [SEED_W-1:0]  pix_seed,
    input  logic [7:0]         walk_col,
    output col_state_t         walk_rdata,
    input  logic               walk_we,
    input  col_state_t         walk_wdata
);

    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    col_state_t       cols [NUM_COLS];
    logic [CW-1:0]    pix_idx;
    logic [CW-1:0]    walk_idx;

    // Off-screen pixel columns read entry 0; the pixel pipeline blanks them.
    assign pix_idx  = (pix_col  < 8'(NUM_COLS)) ? pix_col[CW-1:0]  : '0;
    assign walk_idx = (walk_col < 8'(NUM_COLS)) ? walk_col[CW-1:0] : '0;

    assign pix_head   = cols[pix_idx].head;
    assign pix_trail  = cols[pix_idx].trail;
    assign pix_seed   = cols[pix_idx].seed;
    assign walk_rdata = cols[walk_idx];

    // NOTE: the stagger pattern is visible state, so this array is a reset
    // register file rather than a RAM; every entry gets its reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                cols[i].head  <= HEAD_W'(i % NUM_ROWS);
                cols[i].step  <= '0;
                cols[i].speed <= RESET_SPEED;
                cols[i].trail <= RESET_TRAIL;
                cols[i].seed  <= '0;
            end
        end else if (walk_we) begin
            cols[walk_idx] <= walk_wdata;
        end
    end

endmodule

// File: rtl/glyph_rain_engine.sv
// Falling-glyph "digital rain" renderer: two-stage pixel pipeline driving an
// external glyph ROM, plus a once-per-frame walk that advances every column.
module glyph_rain_engine
    import glyph_rain_pkg::*;
#(
    parameter int NUM_COLS   = 80,
    parameter int NUM_ROWS   = 40,
    parameter int GLYPH_H    = 12,
    parameter int NUM_GLYPHS = 51
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        pause,
    input  logic [1:0]  palette_sel,
    input  logic        display_on,
    input  logic [10:0] hpos,
    input  logic [9:0]  vpos,
    output logic [5:0]  glyph_index,
    output logic [2:0]  glyph_x,
    output logic [3:0]  glyph_y,
    input  logic        glyph_pixel,
    output logic [5:0]  rgb,
    output logic        busy,
    output logic        overrun
);

    walk_state_t        state;
    logic [7:0]         walk_col;
    logic [15:0]        lfsr;
    col_state_t         walk_rd;
    col_state_t         walk_wr;
    logic [HEAD_W-1:0]  pix_head;
    logic [TRAIL_W-1:0] pix_trail;
    logic [SEED_W-1:0]  pix_seed;

    logic [7:0]         s1_col;
    logic [9:0]         s1_row;
    logic [15:0]        gi_sum;
    logic [HEAD_W-1:0]  s2_dist;
    logic [TRAIL_W-1:0] s2_trail;
    logic               s2_valid;
    logic [HEAD_W-1:0]  dist_m1;
    logic [2:0]         shade;
    logic [2:0]         pal_idx;
    rgb_t               rgb_next;

    glyph_rain_column_state #(
        .NUM_COLS (NUM_COLS),
        .NUM_ROWS (NUM_ROWS)
    ) u_cols (
        .clk        (clk),
        .reset      (reset),
        .pix_col    (s1_col),
        .pix_head   (pix_head),
        .pix_trail  (pix_trail),
        .pix_seed   (pix_seed),
        .walk_col   (walk_col),
        .walk_rdata (walk_rd),
        .walk_we    (state == ST_WALK),
        .walk_wdata (walk_wr)
    );

    // Stage 1: locate the glyph cell and fetch the column state it needs.
    assign s1_col = hpos[10:3];
    assign s1_row = vpos / 10'(GLYPH_H);
    assign gi_sum = 16'(s1_col) * 16'd7 + 16'(s1_row) * 16'd13 + 16'(pix_seed);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glyph_index <= '0;
            glyph_x     <= '0;
            glyph_y     <= '0;
            s2_dist     <= '0;
            s2_trail    <= '0;
            s2_valid    <= 1'b0;
        end else begin
            glyph_index <= 6'(gi_sum % 16'(NUM_GLYPHS));
            glyph_x     <= hpos[2:0];
            glyph_y     <= 4'(vpos - s1_row * 10'(GLYPH_H));
            s2_dist     <= pix_head - s1_row[HEAD_W-1:0];
            s2_trail    <= pix_trail;
            s2_valid    <= display_on && (s1_col < 8'(NUM_COLS)) && (s1_row < 10'(NUM_ROWS));
        end
    end

    // Stage 2: shade the ROM pixel by its distance behind the column head.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path can leave a latch behind.
    always_comb begin
        rgb_next = '0;
        dist_m1  = s2_dist - 7'd1;
        shade    = (dist_m1 > 7'd7) ? 3'd7 : dist_m1[2:0];
        pal_idx  = 3'd7 - shade;
        if (s2_valid && glyph_pixel) begin
            if (s2_dist == '0)
                rgb_next = 6'h3F;
            else if (s2_dist <= {3'b000, s2_trail})
                rgb_next = PALETTE[palette_sel][pal_idx];
        end
    end

    // NOTE: sequential state is updated with non-blocking '<=' only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rgb <= '0;
        else       rgb <= rgb_next;
    end

    // Column update applied to the entry under walk_col this cycle.
    always_comb begin
        logic [HEAD_W-1:0] head_adv;
        logic [7:0]        respawn_at;
        walk_wr    = walk_rd;
        head_adv   = walk_rd.head + 7'd1;
        respawn_at = 8'(NUM_ROWS) + {4'b0000, walk_rd.trail};
        if (walk_rd.step == walk_rd.speed) begin
            walk_wr.step = '0;
            walk_wr.seed = (walk_rd.seed == 6'(NUM_GLYPHS - 1)) ? '0 : walk_rd.seed + 6'd1;
            if ({1'b0, head_adv} == respawn_at) begin
                walk_wr.head  = '0;
                walk_wr.speed = lfsr[1:0];
                walk_wr.trail = MIN_TRAIL + {1'b0, lfsr[4:2]};
            end else begin
                walk_wr.head = head_adv;
            end
        end else begin
            walk_wr.step = walk_rd.step + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            walk_col <= '0;
            lfsr     <= LFSR_SEED;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_tick && !pause) begin
                        state    <= ST_WALK;
                        walk_col <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_WALK: begin
                    lfsr <= lfsr_next(lfsr);
                    if (frame_tick && !pause)
                        overrun <= 1'b1;
                    if (walk_col == 8'(NUM_COLS - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        walk_col <= walk_col + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_rain_engine.sv
// Directed bench for glyph_rain_engine: pixel shading, blanking, frame walk,
// overrun, pause, respawn and reset during a walk.
module tb_glyph_rain_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        pause;
    logic [1:0]  palette_sel;
    logic        display_on;
    logic [10:0] hpos;
    logic [9:0]  vpos;
    logic [5:0]  glyph_index;
    logic [2:0]  glyph_x;
    logic [3:0]  glyph_y;
    logic        glyph_pixel;
    logic [5:0]  rgb;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int h; int v; int sel; int gp; int disp;
        int exp_rgb; int exp_gi; int exp_gx; int exp_gy;
    } vec_t;

    // Hand-computed against reset state: head[c] = c mod 40, trail 4, seed 0.
    vec_t vecs [14] = '{
        '{0,    0,   0, 1, 1, 63,   0,  0,  0},
        '{43,   31,  2, 1, 1, 'h0A, 10, 3,  7},
        '{80,   120, 0, 1, 1, 63,   47, 0,  0},
        '{80,   120, 0, 0, 1, 0,    47, 0,  0},
        '{72,   96,  0, 1, 1, 'h2E, 14, 0,  0},
        '{77,   65,  1, 1, 1, 'h30, 26, 5,  5},
        '{87,   71,  0, 1, 1, 0,    33, 7,  11},
        '{16,   60,  0, 1, 1, 0,    28, 0,  0},
        '{160,  216, 3, 1, 1, 'h2A, 17, 0,  0},
        '{632,  468, 0, 1, 1, 63,   40, 0,  0},
        '{0,    0,   0, 1, 0, 0,    0,  0,  0},
        '{640,  0,   0, 1, 1, 0,    50, 0,  0},
        '{320,  480, 0, 1, 1, 0,    35, 0,  0},
        '{1000, 12,  0, 1, 1, 0,    21, 0,  1 - 1}
    };

    glyph_rain_engine dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .pause       (pause),
        .palette_sel (palette_sel),
        .display_on  (display_on),
        .hpos        (hpos),
        .vpos        (vpos),
        .glyph_index (glyph_index),
        .glyph_x     (glyph_x),
        .glyph_y     (glyph_y),
        .glyph_pixel (glyph_pixel),
        .rgb         (rgb),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; frame_tick = 1'b0; pause = 1'b0; palette_sel = 2'd0;
        display_on = 1'b0; hpos = '0; vpos = '0; glyph_pixel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Pulses frame_tick once and returns the number of cycles busy stayed high.
    task automatic run_walk(output int cycles);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; frame_tick = 1'b0; pause = 1'b0; palette_sel = 2'd0;
        display_on = 1'b1; hpos = '0; vpos = '0; glyph_pixel = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rgb !== 6'd0) begin errors++; $display("FAIL reset_rgb: got %0d want 0", rgb); end
        checks++; if (glyph_index !== 6'd0 || glyph_x !== 3'd0 || glyph_y !== 4'd0) begin
            errors++; $display("FAIL reset_glyph: got %0d/%0d/%0d want 0/0/0", glyph_index, glyph_x, glyph_y); end
        checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy %b overrun %b want 0 0", busy, overrun); end
        checks++; if (dut.u_cols.cols[5].head !== 7'd5) begin
            errors++; $display("FAIL reset_head5: got %0d want 5", dut.u_cols.cols[5].head); end
        checks++; if (dut.u_cols.cols[45].head !== 7'd5 || dut.u_cols.cols[79].head !== 7'd39) begin
            errors++; $display("FAIL reset_stagger: got %0d,%0d want 5,39",
                               dut.u_cols.cols[45].head, dut.u_cols.cols[79].head); end
        checks++; if (dut.u_cols.cols[0].speed !== 2'd1 || dut.u_cols.cols[0].trail !== 4'd4 ||
                      dut.u_cols.cols[0].step !== 2'd0 || dut.u_cols.cols[0].seed !== 6'd0) begin
            errors++; $display("FAIL reset_fields: speed %0d trail %0d step %0d seed %0d want 1 4 0 0",
                               dut.u_cols.cols[0].speed, dut.u_cols.cols[0].trail,
                               dut.u_cols.cols[0].step, dut.u_cols.cols[0].seed); end
        checks++; if (dut.lfsr !== 16'hACE1) begin
            errors++; $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pixels();
        do_reset();
        foreach (vecs[i]) begin
            hpos = 11'(vecs[i].h); vpos = 10'(vecs[i].v); palette_sel = 2'(vecs[i].sel);
            glyph_pixel = (vecs[i].gp != 0); display_on = (vecs[i].disp != 0);
            @(negedge clk);
            checks++; if (glyph_index !== 6'(vecs[i].exp_gi) || glyph_x !== 3'(vecs[i].exp_gx) ||
                          glyph_y !== 4'(vecs[i].exp_gy)) begin
                errors++; $display("FAIL pix_glyph[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                                   glyph_index, glyph_x, glyph_y, vecs[i].exp_gi, vecs[i].exp_gx, vecs[i].exp_gy); end
            @(negedge clk);
            checks++; if (rgb !== 6'(vecs[i].exp_rgb)) begin
                errors++; $display("FAIL pix_rgb[%0d]: got %h want %h", i, rgb, 6'(vecs[i].exp_rgb)); end
        end
        display_on = 1'b0;
    endtask

    task automatic test_walk();
        int cyc;
        do_reset();
        run_walk(cyc);
        checks++; if (cyc != 80) begin errors++; $display("FAIL walk1_busy: got %0d cycles want 80", cyc); end
        checks++; if (dut.u_cols.cols[0].head !== 7'd0 || dut.u_cols.cols[0].step !== 2'd1) begin
            errors++; $display("FAIL walk1_col0: head %0d step %0d want 0 1",
                               dut.u_cols.cols[0].head, dut.u_cols.cols[0].step); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL walk1_overrun: got %b want 0", overrun); end
        run_walk(cyc);
        checks++; if (cyc != 80) begin errors++; $display("FAIL walk2_busy: got %0d cycles want 80", cyc); end
        checks++; if (dut.u_cols.cols[0].head !== 7'd1 || dut.u_cols.cols[0].seed !== 6'd1 ||
                      dut.u_cols.cols[1].head !== 7'd2) begin
            errors++; $display("FAIL walk2_heads: col0 %0d seed %0d col1 %0d want 1 1 2",
                               dut.u_cols.cols[0].head, dut.u_cols.cols[0].seed, dut.u_cols.cols[1].head); end
        hpos = 11'd0; vpos = 10'd12; display_on = 1'b1; glyph_pixel = 1'b1; palette_sel = 2'd0;
        @(negedge clk);
        checks++; if (glyph_index !== 6'd14) begin errors++; $display("FAIL walk2_gi: got %0d want 14", glyph_index); end
        @(negedge clk);
        checks++; if (rgb !== 6'd63) begin errors++; $display("FAIL walk2_rgb: got %0d want 63", rgb); end
        display_on = 1'b0;
    endtask

    task automatic test_overrun();
        int cyc;
        do_reset();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            frame_tick = (cyc == 10);
            @(negedge clk);
        end
        frame_tick = 1'b0;
        checks++; if (cyc != 80) begin errors++; $display("FAIL ovr_busy: got %0d cycles want 80", cyc); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
        run_walk(cyc);
        checks++; if (overrun !== 1'b1 || cyc != 80) begin
            errors++; $display("FAIL ovr_sticky: overrun %b cycles %0d want 1 80", overrun, cyc); end
    endtask

    task automatic test_pause();
        int busy_seen = 0;
        do_reset();
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
            for (int j = 0; j < 6; j++) begin
                if (busy !== 1'b0) busy_seen++;
                @(negedge clk);
            end
        end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL pause_busy: busy seen %0d times want 0", busy_seen); end
        checks++; if (dut.u_cols.cols[7].head !== 7'd7 || dut.u_cols.cols[7].step !== 2'd0) begin
            errors++; $display("FAIL pause_state: head %0d step %0d want 7 0",
                               dut.u_cols.cols[7].head, dut.u_cols.cols[7].step); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL pause_overrun: got %b want 0", overrun); end
        pause = 1'b0;
    endtask

    task automatic test_respawn();
        int cyc;
        int ticks = 0;
        logic [6:0]  prev_head = 7'd3;
        logic [6:0]  cur_head = 7'd3;
        logic [15:0] l = 16'hACE1;
        do_reset();
        while (ticks < 100) begin
            run_walk(cyc);
            ticks++;
            prev_head = cur_head;
            cur_head = dut.u_cols.cols[3].head;
            if (cur_head == 7'd0) break;
        end
        checks++; if (ticks != 82 || prev_head !== 7'd43) begin
            errors++; $display("FAIL respawn_when: tick %0d prev head %0d want 82 43", ticks, prev_head); end
        for (int n = 0; n < 81 * 80 + 3; n++) l = lfsr_adv(l);
        checks++; if (cur_head !== 7'd0 || dut.u_cols.cols[3].step !== 2'd0) begin
            errors++; $display("FAIL respawn_head: head %0d step %0d want 0 0", cur_head, dut.u_cols.cols[3].step); end
        checks++; if (dut.u_cols.cols[3].speed !== l[1:0]) begin
            errors++; $display("FAIL respawn_speed: got %0d want %0d", dut.u_cols.cols[3].speed, l[1:0]); end
        checks++; if (dut.u_cols.cols[3].trail !== 4'd4 + {1'b0, l[4:2]}) begin
            errors++; $display("FAIL respawn_trail: got %0d want %0d", dut.u_cols.cols[3].trail, 4 + l[4:2]); end
    endtask

    task automatic test_reset_mid_walk();
        int cyc;
        do_reset();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (dut.u_cols.cols[0].step !== 2'd0 || dut.u_cols.cols[5].head !== 7'd5) begin
            errors++; $display("FAIL midrst_cols: step0 %0d head5 %0d want 0 5",
                               dut.u_cols.cols[0].step, dut.u_cols.cols[5].head); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_resume: busy %b want 0", busy); end
        run_walk(cyc);
        checks++; if (cyc != 80 || dut.u_cols.cols[0].step !== 2'd1) begin
            errors++; $display("FAIL midrst_fresh: cycles %0d step0 %0d want 80 1", cyc, dut.u_cols.cols[0].step); end
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; pause = 1'b0; palette_sel = 2'd0;
        display_on = 1'b0; hpos = '0; vpos = '0; glyph_pixel = 1'b0;
        test_reset();
        test_pixels();
        test_walk();
        test_overrun();
        test_pause();
        test_respawn();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
